// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and RAM geometry for the data-RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  localparam int unsigned RAM_ADDR_W = 11;
  localparam int unsigned RAM_DATA_W = 32;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping at NREQ.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] w_j;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_j   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_j = IDX_W'((32'(ptr) + k) % NREQ);
      if (!valid && req[w_j]) begin
        valid = 1'b1;
        idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NREQ requesters onto the single data-RAM port, one command at a time.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned ADDR_W      = RAM_ADDR_W,
  parameter int unsigned DATA_W      = RAM_DATA_W,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   busy,
  output logic                   ram_w_en,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_in,
  input  logic [DATA_W-1:0]      ram_data
);

  localparam int unsigned IDX_W = (NREQ > 2) ? 2 : 1;
  localparam int unsigned CNT_W = 2;

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              w_latch;
  logic              w_pick_valid;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [IDX_W-1:0]  w_pick_ptr;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [NREQ-1:0]   w_onehot;
  logic              w_rd_done;

  // Fixed priority is just the rotating encoder with its pointer pinned at 0.
  assign w_pick_ptr = (ROUND_ROBIN != 0) ? r_ptr : '0;

  rr_pick #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req  (req),
    .ptr  (w_pick_ptr),
    .valid(w_pick_valid),
    .idx  (w_pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_next  = ISSUE;
          w_latch = 1'b1;
        end
      end
      ISSUE:   w_next = r_we ? IDLE : WAIT;
      WAIT:    if (r_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read commands latch zero write data so ram_in reads 0 during a read issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_idx   <= w_pick_idx;
      r_we    <= req_we[w_pick_idx];
      r_addr  <= req_addr[w_pick_idx*ADDR_W +: ADDR_W];
      r_wdata <= req_we[w_pick_idx] ? req_wdata[w_pick_idx*DATA_W +: DATA_W] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (r_state == ISSUE) begin
      if (ROUND_ROBIN != 0) r_ptr <= (r_idx == IDX_W'(NREQ - 1)) ? '0 : r_idx + 1'b1;
      r_cnt <= CNT_W'(RD_LATENCY - 1);
    end else if (r_state == WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_onehot  = {{(NREQ - 1){1'b0}}, 1'b1} << r_idx;
  assign w_rd_done = (r_state == WAIT) && (r_cnt == '0);

  assign gnt      = (r_state == ISSUE) ? w_onehot : '0;
  assign rvalid   = w_rd_done ? w_onehot : '0;
  assign rdata    = w_rd_done ? ram_data : '0;
  assign busy     = (r_state != IDLE);
  assign ram_w_en = (r_state == ISSUE) && r_we;
  assign ram_addr = r_addr;
  assign ram_in   = r_wdata;

endmodule
